// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// Holds the FSM state encoding, parity mode codes and the frame-length formula.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks from the START edge of one frame to the START edge of the next back-to-back frame.
  function automatic int frame_len(input int clk_div, input int data_bits,
                                   input int parity, input int stop_bits);
    return clk_div * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Upstream valid/ready word channel feeding the UART transmitter FIFO.
// A word transfers on any clock edge where s_valid and s_ready are both high.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word fall-through FIFO: pop_data_o is valid whenever empty_o is low.
// Pointers and occupancy are cleared by the asynchronous reset; storage is not.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (do_pop && !do_push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: input FIFO, compile-time frame format, internal baud divider.
// Queued words are sent back-to-back; the next word is popped on the last STOP clock.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        ap_rst,
  uart_tx_cfg_if.slave                s,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLK_DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two and at least 2");
  end

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = 4;

  uart_state_e          state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 rdy_en_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 push;
  logic                 pop;
  logic                 baud_last;
  logic                 stop_last;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY == PAR_ODD);
  endfunction

  assign baud_last = (baud_q == BAUD_W'(CLK_DIV - 1));
  assign stop_last = (state_q == ST_STOP) && baud_last && (bit_q == BIT_W'(STOP_BITS - 1));
  assign pop       = ~fifo_empty & ((state_q == ST_IDLE) | stop_last);

  // Ready depends only on registered state, never on s_valid.
  assign s.s_ready = rdy_en_q & ~fifo_full;
  assign push      = s.s_valid & s.s_ready;

  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE) | ~fifo_empty;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (ap_rst),
    .push_i      (push),
    .push_data_i (s.s_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  always_ff @(posedge clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift_q <= fifo_data;
            par_q   <= par_of(fifo_data);
            state_q <= ST_START;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_last) begin
            state_q <= ST_DATA;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
              bit_q <= '0;
              if (PARITY != PAR_NONE) begin
                state_q <= ST_PAR;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_PAR: begin
          if (baud_last) begin
            state_q <= ST_STOP;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == BIT_W'(STOP_BITS - 1)) begin
              bit_q <= '0;
              // Zero-gap chaining: the next queued word starts on this same edge.
              if (!fifo_empty) begin
                shift_q <= fifo_data;
                par_q   <= par_of(fifo_data);
                state_q <= ST_START;
                tx_q    <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four differently configured instances checked every cycle
// against a frame-schedule reference model, plus directed frame captures.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst;
  logic [3:0] sv;
  logic [8:0] sd [4];
  logic [3:0] tx_w, busy_w, rdy_w;
  int         lvl_w [4];
  logic [2:0] lvl0;
  logic [4:0] lvl1, lvl2;
  logic [1:0] lvl3;

  int cdiv  [4] = '{4, 3, 2, 12};
  int dbits [4] = '{8, 7, 8, 9};
  int pmode [4] = '{PAR_EVEN, PAR_NONE, PAR_ODD, PAR_NONE};
  int sbits [4] = '{1, 2, 1, 1};
  int fdep  [4] = '{4, 16, 16, 2};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int cap [16];

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(9)) if3 ();

  assign if0.s_data = sd[0][7:0];
  assign if1.s_data = sd[1][6:0];
  assign if2.s_data = sd[2][7:0];
  assign if3.s_data = sd[3];
  assign if0.s_valid = sv[0];
  assign if1.s_valid = sv[1];
  assign if2.s_valid = sv[2];
  assign if3.s_valid = sv[3];
  assign rdy_w = {if3.s_ready, if2.s_ready, if1.s_ready, if0.s_ready};
  assign lvl_w[0] = int'(lvl0);
  assign lvl_w[1] = int'(lvl1);
  assign lvl_w[2] = int'(lvl2);
  assign lvl_w[3] = int'(lvl3);

  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .ap_rst(rst[0]), .s(if0), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_level(lvl0));
  uart_tx_cfg #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) dut1 (
    .clk(clk), .ap_rst(rst[1]), .s(if1), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_level(lvl1));
  uart_tx_cfg #(.CLK_DIV(2), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut2 (
    .clk(clk), .ap_rst(rst[2]), .s(if2), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_level(lvl2));
  uart_tx_cfg #(.CLK_DIV(12), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(2)) dut3 (
    .clk(clk), .ap_rst(rst[3]), .s(if3), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_level(lvl3));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus the position inside the frame on the line.
  int mq [4][$];
  bit mact [4];
  bit mren [4];
  int mpos [4];
  int mword [4];

  function automatic int exp_bit(input int d, input int w, input int pos);
    int b;
    int p;
    b = pos / cdiv[d];
    if (b == 0) return 0;
    if (b <= dbits[d]) return (w >> (b - 1)) & 1;
    if (pmode[d] != PAR_NONE && b == dbits[d] + 1) begin
      p = $countones(w) % 2;
      return (pmode[d] == PAR_ODD) ? 1 - p : p;
    end
    return 1;
  endfunction

  task automatic model_step(input int d);
    bit push;
    int f;
    if (rst[d]) begin
      mq[d].delete();
      mact[d] = 1'b0;
      mren[d] = 1'b0;
      mpos[d] = 0;
      return;
    end
    push = sv[d] && mren[d] && (mq[d].size() < fdep[d]);
    f = frame_len(cdiv[d], dbits[d], pmode[d], sbits[d]);
    if (mact[d]) begin
      mpos[d]++;
      if (mpos[d] == f) begin
        if (mq[d].size() > 0) begin
          mword[d] = mq[d].pop_front();
          mpos[d]  = 0;
        end else begin
          mact[d] = 1'b0;
        end
      end
    end else if (mq[d].size() > 0) begin
      mword[d] = mq[d].pop_front();
      mact[d]  = 1'b1;
      mpos[d]  = 0;
    end
    if (push) mq[d].push_back(int'(sd[d]) & ((1 << dbits[d]) - 1));
    mren[d] = 1'b1;
  endtask

  task automatic model_check(input int d);
    int etx;
    int lvl;
    etx = mact[d] ? exp_bit(d, mword[d], mpos[d]) : 1;
    lvl = mq[d].size();
    chk($sformatf("tx%0d", d), int'(tx_w[d]), etx);
    chk($sformatf("level%0d", d), lvl_w[d], lvl);
    chk($sformatf("ready%0d", d), int'(rdy_w[d]), (mren[d] && lvl < fdep[d]) ? 1 : 0);
    chk($sformatf("busy%0d", d), int'(busy_w[d]), (mact[d] || lvl > 0) ? 1 : 0);
  endtask

  always begin
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 4; d++) model_step(d);
    #1;
    for (int d = 0; d < 4; d++) model_check(d);
  end

  // All driving tasks start and end on a falling edge.
  task automatic push_word(input int d, input int w);
    int n;
    n = 0;
    sd[d] = 9'(w);
    sv[d] = 1'b1;
    while (!rdy_w[d] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("push_wait%0d", d), (n >= 3000) ? 1 : 0, 0);
    @(negedge clk);
    sv[d] = 1'b0;
  endtask

  task automatic capture(input int d, input int nb, output int lat, output int st);
    lat = 0;
    while (tx_w[d] && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    st = cyc;
    repeat (cdiv[d] / 2) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      cap[i] = int'(tx_w[d]);
      if (i < nb - 1) repeat (cdiv[d]) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int d, output int fall);
    int n;
    n = 0;
    while (busy_w[d] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_wait%0d", d), (n >= 5000) ? 1 : 0, 0);
    fall = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t want finish", $time);
    $fatal(1, "watchdog expired");
  end

  int exp_a5 [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

  initial begin
    int lat, st, fall, e1, acc, n, w, d, nlow, nbusy;
    rst = 4'hF;
    sv  = 4'h0;
    for (int i = 0; i < 4; i++) sd[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx_w), 15);
    chk("rst_busy", int'(busy_w), 0);
    chk("rst_ready", int'(rdy_w), 0);
    rst = 4'h0;
    @(negedge clk);
    chk("ready_after_release", int'(rdy_w), 15);

    // 8E1, CLK_DIV=4, word 0xA5
    push_word(0, 'hA5);
    capture(0, 11, lat, st);
    chk("a5_latency", lat, 1);
    for (int i = 0; i < 11; i++) chk($sformatf("a5_bit%0d", i), cap[i], exp_a5[i]);
    wait_idle(0, fall);
    chk("a5_busy_span", fall - st, 44);

    // Parity of 0x07: even on dut0, odd on dut2
    push_word(0, 'h07);
    capture(0, 11, lat, st);
    chk("even_parity", cap[9], 1);
    wait_idle(0, fall);
    push_word(2, 'h07);
    capture(2, 11, lat, st);
    chk("odd_latency", lat, 1);
    chk("odd_parity", cap[9], 0);
    chk("odd_stop", cap[10], 1);
    wait_idle(2, fall);

    // 7N2, three words on consecutive cycles
    push_word(1, 'h35);
    e1 = cyc;
    push_word(1, 'h4A);
    push_word(1, 'h7F);
    wait_idle(1, fall);
    chk("7n2_span", fall - e1, 91);

    // FIFO_DEPTH=4 with s_valid held high
    acc = 0;
    sv[0] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      sd[0] = 9'($urandom_range(0, 255));
      if (!rdy_w[0]) break;
      acc++;
      @(negedge clk);
    end
    sv[0] = 1'b0;
    chk("full_accepted", acc, 5);
    n = 0;
    while (!rdy_w[0] && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("full_ready_low_cycles", n, 41);
    wait_idle(0, fall);

    // Reset in the middle of data bit 0 (clock 10) on dut3
    push_word(3, 'h1C3);
    push_word(3, 'h0F5);
    repeat (22) @(posedge clk);
    #2;
    chk("pre_rst_level", lvl_w[3], 1);
    chk("pre_rst_tx", int'(tx_w[3]), 1);
    rst[3] = 1'b1;
    #1;
    chk("rst_mid_tx", int'(tx_w[3]), 1);
    chk("rst_mid_level", lvl_w[3], 0);
    chk("rst_mid_busy", int'(busy_w[3]), 0);
    repeat (3) @(negedge clk);
    rst[3] = 1'b0;
    @(negedge clk);
    w = 'h12B;
    push_word(3, w);
    capture(3, 11, lat, st);
    chk("post_rst_latency", lat, 1);
    chk("post_rst_start", cap[0], 0);
    for (int i = 1; i <= 9; i++) chk($sformatf("post_rst_bit%0d", i), cap[i], (w >> (i - 1)) & 1);
    chk("post_rst_stop", cap[10], 1);
    wait_idle(3, fall);

    // Random traffic across all instances
    for (int k = 0; k < 60; k++) begin
      d = int'($urandom_range(0, 3));
      push_word(d, int'($urandom_range(0, 511)));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    for (int i = 0; i < 4; i++) wait_idle(i, fall);

    // Idle line
    nlow  = 0;
    nbusy = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_w != 4'hF) nlow++;
      if (busy_w != 4'h0) nbusy++;
    end
    chk("idle_tx_low", nlow, 0);
    chk("idle_busy", nbusy, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
